// File: rtl/lea_pkg.sv
// Shared types and helpers for the LEA-128 keypad session controller.
package lea_pkg;

  localparam int unsigned NBYTES  = 16;
  localparam int unsigned BLOCK_W = NBYTES * 8;

  // One-hot keypad bit positions; bits 0..9 are the digits.
  localparam int unsigned NKEYS     = 12;
  localparam int unsigned KEY_STAR  = 10;
  localparam int unsigned KEY_SHARP = 11;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    StKeyEntry,
    StTextEntry,
    StEncStart,
    StEncWait,
    StDecStart,
    StDecWait,
    StDone,
    StError
  } state_e;

  // Byte 0 lives in the most significant byte of the block.
  function automatic block_t put_byte(input block_t data, input logic [4:0] idx,
                                      input logic [7:0] val);
    block_t r;
    r = data;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == 5'(i)) r[(NBYTES-1-i)*8 +: 8] = val;
    end
    return r;
  endfunction

  // Fill every byte at or above position cnt with the pad value.
  function automatic block_t pad_from(input block_t data, input logic [4:0] cnt,
                                      input logic [7:0] pad);
    block_t r;
    r = data;
    for (int i = 0; i < NBYTES; i++) begin
      if (5'(i) >= cnt) r[(NBYTES-1-i)*8 +: 8] = pad;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_edge.sv
// Keypad press detector: accepts a key only when the pad goes from idle to exactly one
// key down, and presents a registered one-cycle event decoded as digit, star or sharp.
module keypad_edge
  import lea_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] keypad,
  output logic             ev_digit,
  output logic             ev_star,
  output logic             ev_sharp,
  output logic [3:0]       digit
);

  logic [NKEYS-1:0] prev_q;
  logic             press;
  logic [3:0]       digit_enc;
  logic             ev_digit_q, ev_star_q, ev_sharp_q;
  logic [3:0]       digit_q;

  // Press qualification and digit encoding of the current pad sample.
  always_comb begin
    press     = (prev_q == '0) && $onehot(keypad);
    digit_enc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) digit_enc = 4'(i);
    end
  end

  // Previous-sample history and registered key events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      ev_digit_q <= 1'b0;
      ev_star_q  <= 1'b0;
      ev_sharp_q <= 1'b0;
      digit_q    <= 4'd0;
    end else begin
      prev_q     <= keypad;
      ev_digit_q <= press && (|keypad[9:0]);
      ev_star_q  <= press && keypad[KEY_STAR];
      ev_sharp_q <= press && keypad[KEY_SHARP];
      digit_q    <= digit_enc;
    end
  end

  assign ev_digit = ev_digit_q;
  assign ev_star  = ev_star_q;
  assign ev_sharp = ev_sharp_q;
  assign digit    = digit_q;

endmodule

// File: rtl/lea_session_ctrl.sv
// Session sequencer: collects key and plaintext from the keypad, runs one encrypt and one
// decrypt pass through the shared LEA core and reports whether the round trip matched.
module lea_session_ctrl
  import lea_pkg::*;
#(
  parameter logic [7:0]  ASCII_BASE = 8'h30,
  parameter logic [7:0]  PAD_BYTE   = 8'h20,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NKEYS-1:0]   Keypad,
  output logic               core_start,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_din,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_dout,
  output logic [BLOCK_W-1:0] Out_Encrypted,
  output logic [BLOCK_W-1:0] Out_Decrypted,
  output logic [BLOCK_W-1:0] text_buf,
  output logic [4:0]         entry_cnt,
  output logic               CHK_Key,
  output logic               CHK_Text,
  output logic               CHK,
  output logic               err,
  output logic               lcd_refresh
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic       ev_digit, ev_star, ev_sharp;
  logic [3:0] digit;

  keypad_edge u_keypad_edge (
    .clk      (CLK),
    .rst_n    (RST),
    .keypad   (Keypad),
    .ev_digit (ev_digit),
    .ev_star  (ev_star),
    .ev_sharp (ev_sharp),
    .digit    (digit)
  );

  state_e  state_q, state_d;
  block_t  key_q, key_d, text_q, text_d, enc_q, enc_d, dec_q, dec_d;
  block_t  cur, cur_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic chk_key_q, chk_key_d, chk_text_q, chk_text_d, chk_q, chk_d, err_q, err_d;
  logic start_q, start_d, mode_q, mode_d, refresh_q, refresh_d;
  logic clear_run, clear_all;

  // Next-state: entry editing, core sequencing, timeout and session clears.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    text_d     = text_q;
    enc_d      = enc_q;
    dec_d      = dec_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    chk_key_d  = chk_key_q;
    chk_text_d = chk_text_q;
    chk_d      = chk_q;
    err_d      = err_q;
    mode_d     = mode_q;
    start_d    = 1'b0;
    clear_run  = 1'b0;
    clear_all  = 1'b0;
    // Entry edits apply to whichever buffer is currently being typed.
    cur        = (state_q == StTextEntry) ? text_q : key_q;
    cur_d      = cur;

    case (state_q)
      StKeyEntry, StTextEntry: begin
        if (ev_digit) begin
          if (cnt_q < 5'(NBYTES)) begin
            cur_d = put_byte(cur, cnt_q, ASCII_BASE + {4'd0, digit});
            cnt_d = cnt_q + 5'd1;
          end
        end else if (ev_star) begin
          if (cnt_q != 5'd0) begin
            cur_d = put_byte(cur, cnt_q - 5'd1, 8'h00);
            cnt_d = cnt_q - 5'd1;
          end
        end else if (ev_sharp && (cnt_q != 5'd0)) begin
          cur_d = pad_from(cur, cnt_q, PAD_BYTE);
          cnt_d = 5'd0;
          if (state_q == StKeyEntry) begin
            chk_key_d = 1'b1;
            state_d   = StTextEntry;
          end else begin
            chk_text_d = 1'b1;
            state_d    = StEncStart;
          end
        end
        if (state_q == StTextEntry) text_d = cur_d;
        else                        key_d  = cur_d;
      end
      StEncStart: begin
        start_d = 1'b1;
        mode_d  = 1'b0;
        tmo_d   = '0;
        state_d = StEncWait;
      end
      StEncWait: begin
        if (core_done) begin
          enc_d   = core_dout;
          state_d = StDecStart;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StError;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StDecStart: begin
        start_d = 1'b1;
        mode_d  = 1'b1;
        tmo_d   = '0;
        state_d = StDecWait;
      end
      StDecWait: begin
        if (core_done) begin
          dec_d   = core_dout;
          chk_d   = (core_dout == text_q);
          state_d = StDone;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StError;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StDone: begin
        if (ev_sharp) begin
          clear_run = 1'b1;
          state_d   = StTextEntry;
        end else if (ev_star) begin
          clear_all = 1'b1;
        end
      end
      StError: begin
        if (ev_star) clear_all = 1'b1;
      end
      default: state_d = StKeyEntry;
    endcase

    if (clear_run || clear_all) begin
      text_d     = '0;
      enc_d      = '0;
      dec_d      = '0;
      chk_text_d = 1'b0;
      chk_d      = 1'b0;
      mode_d     = 1'b0;
    end
    if (clear_all) begin
      key_d     = '0;
      cnt_d     = 5'd0;
      chk_key_d = 1'b0;
      err_d     = 1'b0;
      state_d   = StKeyEntry;
    end

    refresh_d = (state_d != state_q) || (key_d != key_q) || (text_d != text_q) ||
                (enc_d != enc_q) || (dec_d != dec_q) || (cnt_d != cnt_q) ||
                (chk_key_d != chk_key_q) || (chk_text_d != chk_text_q) ||
                (chk_d != chk_q) || (err_d != err_q) || (mode_d != mode_q);
  end

  // Session state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StKeyEntry;
      key_q      <= '0;
      text_q     <= '0;
      enc_q      <= '0;
      dec_q      <= '0;
      cnt_q      <= 5'd0;
      tmo_q      <= '0;
      chk_key_q  <= 1'b0;
      chk_text_q <= 1'b0;
      chk_q      <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      refresh_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      text_q     <= text_d;
      enc_q      <= enc_d;
      dec_q      <= dec_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      chk_key_q  <= chk_key_d;
      chk_text_q <= chk_text_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      start_q    <= start_d;
      mode_q     <= mode_d;
      refresh_q  <= refresh_d;
    end
  end

  assign core_start    = start_q;
  assign core_mode     = mode_q;
  assign core_key      = chk_key_q ? key_q : '0;
  assign core_din      = mode_q ? enc_q : text_q;
  assign Out_Encrypted = enc_q;
  assign Out_Decrypted = dec_q;
  assign text_buf      = text_q;
  assign entry_cnt     = cnt_q;
  assign CHK_Key       = chk_key_q;
  assign CHK_Text      = chk_text_q;
  assign CHK           = chk_q;
  assign err           = err_q;
  assign lcd_refresh   = refresh_q;

endmodule
